// File: rtl/gate_in_debounce.sv
// Three-channel gate input debouncer: each raw pad level is double-flop synchronized,
// then accepted only after LIMIT consecutive differing samples.
module gate_in_debounce #(
   parameter int CNT_W = 4,
   parameter int LIMIT = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       raw1,
   input  logic       raw2,
   input  logic       raw3,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic [2:0] chg
);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0] w_raw;
   logic [2:0] r_s1;
   logic [2:0] r_s2;

   assign w_raw = {raw3, raw2, raw1};

   // Two-flop synchronizer; keeps running regardless of en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_in;
      logic             w_in_nxt;
      logic             r_chg;
      logic             w_chg_nxt;

      // A counter already at LIMIT-1 accepts on this edge; with LIMIT=1 that is
      // the STABLE case itself, since the counter then sits at 0.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_in_nxt    = r_in;
         w_chg_nxt   = 1'b0;
         if (!en) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
         end else if (r_s2[g] != r_in) begin
            if (r_cnt == LIM_M1) begin
               w_in_nxt    = r_s2[g];
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STABLE;
               w_chg_nxt   = 1'b1;
            end else if (r_state == ST_STABLE) begin
               w_cnt_nxt   = CNT_ONE;
               w_state_nxt = ST_PENDING;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_ONE;
            end
         end else begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_in    <= 1'b0;
            r_chg   <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_in    <= w_in_nxt;
            r_chg   <= w_chg_nxt;
         end
      end
   end

   assign in1 = g_ch[0].r_in;
   assign in2 = g_ch[1].r_in;
   assign in3 = g_ch[2].r_in;
   assign chg = {g_ch[2].r_chg, g_ch[1].r_chg, g_ch[0].r_chg};

endmodule

// File: doc/gate_in_debounce.md
GATE_IN_DEBOUNCE -- requirements
Module: gate_in_debounce

Interface
REQ-001 Parameter CNT_W, default 4: width of each per-channel debounce counter.
REQ-002 Parameter LIMIT, default 10: consecutive differing samples required to accept a new level; legal range 1 .. 2^CNT_W-1.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 EN  input  1  debounce enable; 0 freezes output levels and clears counters.
REQ-006 RAW1, RAW2, RAW3  input  1 each  asynchronous raw levels (switches/pads), unsynchronized.
REQ-007 IN1, IN2, IN3  output  1 each  registered debounced levels; drive the gate block inputs of the same names.
REQ-008 CHG  output  3  per-channel change strobe; bit0=IN1, bit1=IN2, bit2=IN3.

Function
REQ-009 Three identical, independent channels SHALL be implemented; no channel state SHALL affect another.
REQ-010 Each RAWn SHALL pass through a two-flop synchronizer (S1, S2) before any other logic; S2 is the sampled value.
REQ-011 Each channel SHALL keep one state bit: STABLE (counter = 0) or PENDING (counter > 0).
REQ-012 STABLE -> PENDING when EN=1 and S2 != INn at a rising edge; counter loads 1.
REQ-013 PENDING, S2 == INn: return to STABLE, counter cleared to 0, INn unchanged (glitch rejected).
REQ-014 PENDING, S2 != INn, counter < LIMIT-1: counter increments by 1.
REQ-015 S2 != INn with counter == LIMIT-1 (including LIMIT=1 from STABLE): INn <= S2, counter <= 0, state STABLE, CHG bit set, all at the same edge.
REQ-016 Counter SHALL never exceed LIMIT-1 and SHALL never wrap.
REQ-017 Latency: RAWn changing and held before rising edge E SHALL make INn change at edge E+LIMIT+1, exactly.
REQ-018 CHG bit SHALL be high for exactly the one cycle following the edge where its INn changed, low otherwise; no back-to-back pulses possible with LIMIT>=1 except across independent changes.
REQ-019 EN=0: counters forced to 0, INn held, CHG = 000; synchronizer keeps running. EN returning to 1 restarts counting from 0.
REQ-020 Simultaneous changes on several channels SHALL update the affected INn and CHG bits on the same edge.
REQ-021 INn and CHG SHALL come directly from flops; no combinational path from RAWn or EN to outputs.

Reset
REQ-022 RST_N=0 SHALL immediately clear S1, S2, counters, state, IN1..IN3 and CHG to 0, independent of CLK.
REQ-023 Reset asserted mid-count SHALL discard the pending count; after release a new level needs full LIMIT+1 latency from its first capturing edge.
REQ-024 RST_N deassertion is assumed synchronous to CLK by the system reset generator; block adds no reset synchronizer.

Verification (LIMIT=4, CNT_W=4, EN=1 unless stated)
REQ-025 Reset with RAW=000, then RAW1..RAW3 at 111 during reset -> IN1..IN3=000, CHG=000 throughout reset.
REQ-026 RAW1 0->1 before edge E, held -> IN1=1 and CHG=001 after edge E+5; CHG=000 after E+6; IN2, IN3 unchanged.
REQ-027 RAW2 high for 3 cycles then low -> IN2 stays 0, CHG stays 000; counter returns to 0.
REQ-028 RAW3 bouncing 1/0 every 2 cycles for 10 cycles, final 1 captured at edge E -> IN3 rises after E+5 only, single CHG[2] pulse.
REQ-029 RAW1..RAW3 all 0->1 before edge E -> IN1..IN3=111 and CHG=111 after E+5, simultaneously.
REQ-030 RAW1 held 1, RST_N pulsed low at E+3 and released -> IN1=0 immediately; IN1 rises LIMIT+1 edges after first post-release capturing edge; separately, EN=0 at E+3 -> IN1 stays 0 until EN=1, then rises 4 edges later.
